// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the shared system bus.
//   Master 0 = CPU, master 1 = DMA controller (m1_gnt_ drives the DMA free_ input).
//   Grants one master at a time, with a one-cycle HANDOFF turnaround between owners,
//   and a MAX_HOLD limit on consecutive grant cycles while the other master waits.
//   Optional macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests are
//   resolved round-robin (the master that was not last wins). When undefined,
//   the CPU wins simultaneous requests unless a forced release is pending.

`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef Read
`define Read 1'b1
`endif
`ifndef Write
`define Write 1'b0
`endif

module bus_arbiter #(
    parameter int ADDR_W   = `BUS_ADDR_WIDTH,
    parameter int DATA_W   = `DATA_WIDTH,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              m0_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_rw_,
    input  logic              m0_cs_,
    output logic              m0_gnt_,
    input  logic              m1_req_,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_rw_,
    input  logic              m1_cs_,
    output logic              m1_gnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rw_,
    output logic              bus_cs_,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT0    = 2'd1,
        GNT1    = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    // Last legal hold_cnt value; reaching it with a waiting competitor forces release.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic       last, last_nxt;
    logic       preempt, preempt_nxt;
    logic       owner_nxt;
    logic       want0, want1;
    logic       pick1, mine, other;

    assign want0 = ~m0_req_;
    assign want1 = ~m1_req_;

    // Grants and busy decode directly from the registered state.
    assign m0_gnt_ = (state != GNT0);
    assign m1_gnt_ = (state != GNT1);
    assign busy    = (state == GNT0) || (state == GNT1);

    // State, hold counter and arbitration history registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            preempt  <= 1'b0;
            owner    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            preempt  <= preempt_nxt;
            owner    <= owner_nxt;
        end
    end

    // Next-state: arbitrate in IDLE/HANDOFF, enforce release rules while granted.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        last_nxt    = last;
        preempt_nxt = preempt;
        owner_nxt   = owner;
        pick1       = 1'b0;
        mine        = 1'b0;
        other       = 1'b0;

        if (want0 && want1) begin
            if (preempt) begin
                pick1 = ~last;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                pick1 = ~last;
`else
                pick1 = 1'b0;
`endif
            end
        end else begin
            pick1 = want1;
        end

        case (state)
            IDLE, HANDOFF: begin
                if (want0 || want1) begin
                    state_nxt   = pick1 ? GNT1 : GNT0;
                    last_nxt    = pick1;
                    owner_nxt   = pick1;
                    hold_nxt    = '0;
                    preempt_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT0, GNT1: begin
                mine  = (state == GNT1) ? want1 : want0;
                other = (state == GNT1) ? want0 : want1;
                if (!mine) begin
                    state_nxt   = HANDOFF;
                    preempt_nxt = 1'b0;
                end else if (other && (hold_cnt == HOLD_LAST)) begin
                    state_nxt   = HANDOFF;
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus mux: route the granted master, park the bus otherwise.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rw_   = `Read;
        bus_cs_   = 1'b1;
        case (state)
            GNT0: begin
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
                bus_rw_   = m0_rw_;
                bus_cs_   = m0_cs_;
            end
            GNT1: begin
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
                bus_rw_   = m1_rw_;
                bus_cs_   = m1_cs_;
            end
            default: ;
        endcase
    end

    // Both grants must never be asserted together.
    assert property (@(posedge clk) disable iff (!rst_) !(!m0_gnt_ && !m1_gnt_));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and constrained-random bench for bus_arbiter.
// Two instances share the stimulus: u16 (MAX_HOLD=16) and u4 (MAX_HOLD=4).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        m0_req_ = 1'b1, m0_rw_ = 1'b1, m0_cs_ = 1'b1;
    logic        m1_req_ = 1'b1, m1_rw_ = 1'b1, m1_cs_ = 1'b1;
    logic [15:0] m0_addr = 16'hA000, m0_wdata = 16'h0C0C;
    logic [15:0] m1_addr = 16'hB111, m1_wdata = 16'hD1D1;

    logic        g0_a, g1_a, rw_a, cs_a, own_a, busy_a;
    logic [15:0] addr_a, wdata_a;
    logic        g0_b, g1_b, rw_b, cs_b, own_b, busy_b;
    logic [15:0] addr_b, wdata_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_on  = 0;
    int wait0   = 0;
    int wait1   = 0;

    bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(16)) u16 (
        .clk(clk), .rst_(rst_),
        .m0_req_(m0_req_), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw_(m0_rw_),
        .m0_cs_(m0_cs_), .m0_gnt_(g0_a),
        .m1_req_(m1_req_), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw_(m1_rw_),
        .m1_cs_(m1_cs_), .m1_gnt_(g1_a),
        .bus_addr(addr_a), .bus_wdata(wdata_a), .bus_rw_(rw_a), .bus_cs_(cs_a),
        .owner(own_a), .busy(busy_a)
    );

    bus_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(4)) u4 (
        .clk(clk), .rst_(rst_),
        .m0_req_(m0_req_), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw_(m0_rw_),
        .m0_cs_(m0_cs_), .m0_gnt_(g0_b),
        .m1_req_(m1_req_), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw_(m1_rw_),
        .m1_cs_(m1_cs_), .m1_gnt_(g1_b),
        .bus_addr(addr_b), .bus_wdata(wdata_b), .bus_rw_(rw_b), .bus_cs_(cs_b),
        .owner(own_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_ = 1'b0;
        #1;
        check("async_rst_g0", {31'd0, g0_a}, 1);
        check("async_rst_g1", {31'd0, g1_a}, 1);
        rst_ = 1'b1;
    endtask

    // Invariants and the waiting bound during the random phase.
    always @(negedge clk) begin
        if (rnd_on) begin
            check("mutex_16", {31'd0, (g0_a | g1_a)}, 1);
            check("mutex_4",  {31'd0, (g0_b | g1_b)}, 1);
            if (!busy_a) check("idle_cs_16", {31'd0, cs_a}, 1);
            if (!busy_b) check("idle_cs_4",  {31'd0, cs_b}, 1);
            if (!g0_b) check("mux_addr0", {16'd0, addr_b}, {16'd0, m0_addr});
            if (!g1_b) check("mux_wdata1", {16'd0, wdata_b}, {16'd0, m1_wdata});
            if (!m0_req_ && g0_b) begin
                if (wait0 > 0 || !g1_b) wait0++;
            end else wait0 = 0;
            if (!m1_req_ && g1_b) begin
                if (wait1 > 0 || !g0_b) wait1++;
            end else wait1 = 0;
            if (wait0 > 0) check("wait0_bound", {31'd0, (wait0 <= 5)}, 1);
            if (wait1 > 0) check("wait1_bound", {31'd0, (wait1 <= 5)}, 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold0, hold1, gap0, gap1;

        // Reset values
        #1 rst_ = 1'b0;
        #1;
        check("rst_g0",    {31'd0, g0_a}, 1);
        check("rst_g1",    {31'd0, g1_a}, 1);
        check("rst_busy",  {31'd0, busy_a}, 0);
        check("rst_owner", {31'd0, own_a}, 0);
        check("rst_cs",    {31'd0, cs_a}, 1);
        check("rst_rw",    {31'd0, rw_a}, 1);
        check("rst_addr",  {16'd0, addr_a}, 0);
        check("rst_wdata", {16'd0, wdata_a}, 0);
        cyc();
        cyc();

        // DMA alone right after reset release, then asynchronous reset mid-grant
        m1_req_ = 1'b0; m1_cs_ = 1'b0; m1_rw_ = 1'b0;
        rst_ = 1'b1;
        cyc();
        check("t1_g1",    {31'd0, g1_a}, 0);
        check("t1_g0",    {31'd0, g0_a}, 1);
        check("t1_addr",  {16'd0, addr_a}, 32'hB111);
        check("t1_wdata", {16'd0, wdata_a}, 32'hD1D1);
        check("t1_cs",    {31'd0, cs_a}, 0);
        check("t1_rw",    {31'd0, rw_a}, 0);
        check("t1_owner", {31'd0, own_a}, 1);
        check("t1_busy",  {31'd0, busy_a}, 1);
        #2 rst_ = 1'b0;
        #1;
        check("t1_rst_g1",    {31'd0, g1_a}, 1);
        check("t1_rst_cs",    {31'd0, cs_a}, 1);
        check("t1_rst_owner", {31'd0, own_a}, 0);
        m1_req_ = 1'b1; m1_cs_ = 1'b1; m1_rw_ = 1'b1;
        cyc();
        rst_ = 1'b1;

        // CPU alone for 5 grant cycles, then release
        m0_req_ = 1'b0; m0_cs_ = 1'b0; m0_rw_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_g0",   {31'd0, g0_a}, 0);
            check("t2_addr", {16'd0, addr_a}, 32'hA000);
        end
        m0_req_ = 1'b1; m0_cs_ = 1'b1;
        cyc();
        check("t2_ho_g0",    {31'd0, g0_a}, 1);
        check("t2_ho_g1",    {31'd0, g1_a}, 1);
        check("t2_ho_cs",    {31'd0, cs_a}, 1);
        check("t2_ho_busy",  {31'd0, busy_a}, 0);
        check("t2_ho_owner", {31'd0, own_a}, 0);
        cyc();
        check("t2_idle_busy", {31'd0, busy_a}, 0);
        check("t2_idle_g0",   {31'd0, g0_a}, 1);

        // Simultaneous requests from reset (last=1)
        pulse_reset();
        m0_req_ = 1'b0; m1_req_ = 1'b0;
        cyc();
        check("t3_first_g0", {31'd0, g0_a}, 0);
        check("t3_first_g1", {31'd0, g1_a}, 1);
        m0_req_ = 1'b1;
        cyc();
        check("t3_ho_g0", {31'd0, g0_a}, 1);
        check("t3_ho_g1", {31'd0, g1_a}, 1);
        m0_req_ = 1'b0;
        cyc();
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_second_g1", {31'd0, g1_a}, 0);
        check("t3_second_own", {31'd0, own_a}, 1);
`else
        check("t3_second_g0", {31'd0, g0_a}, 0);
        check("t3_second_own", {31'd0, own_a}, 0);
`endif
        m0_req_ = 1'b1; m1_req_ = 1'b1;
        cyc();
        cyc();
        check("t3_idle_busy", {31'd0, busy_a}, 0);

        // Forced release: CPU granted, DMA waits continuously (u4 has MAX_HOLD=4)
        pulse_reset();
        m0_req_ = 1'b0;
        cyc();
        m1_req_ = 1'b0;
        check("t4_g0_c1", {31'd0, g0_b}, 0);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            check("t4_g0_hold", {31'd0, g0_b}, 0);
        end
        cyc();
        check("t4_ho_g0", {31'd0, g0_b}, 1);
        check("t4_ho_g1", {31'd0, g1_b}, 1);
        check("t4_ho_cs", {31'd0, cs_b}, 1);
        check("t4_u16_still_g0", {31'd0, g0_a}, 0);
        cyc();
        check("t4_g1",  {31'd0, g1_b}, 0);
        check("t4_own", {31'd0, own_b}, 1);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            check("t4_g1_hold", {31'd0, g1_b}, 0);
        end
        cyc();
        check("t4_ho2_g0", {31'd0, g0_b}, 1);
        check("t4_ho2_g1", {31'd0, g1_b}, 1);
        cyc();
        check("t4_back_g0", {31'd0, g0_b}, 0);
        m0_req_ = 1'b1; m1_req_ = 1'b1;
        cyc();
        cyc();
        check("t4_idle_busy", {31'd0, busy_b}, 0);

        // DMA alone for 40 cycles: no release, counter saturates
        pulse_reset();
        m1_req_ = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            check("t5_g1", {31'd0, g1_a}, 0);
        end
        check("t5_hold16", {24'd0, u16.hold_cnt}, 15);
        check("t5_hold4",  {24'd0, u4.hold_cnt}, 3);
        check("t5_g1_u4",  {31'd0, g1_b}, 0);
        m1_req_ = 1'b1;
        cyc();
        cyc();

        // Random request streams reacting to the u4 grants
        pulse_reset();
        hold0 = 0; hold1 = 0; gap0 = 0; gap1 = 0;
        rnd_on = 1;
        for (int i = 0; i < 10000; i++) begin
            cyc();
            m0_addr  = 16'($urandom); m0_wdata = 16'($urandom);
            m1_addr  = 16'($urandom); m1_wdata = 16'($urandom);
            m0_cs_   = 1'($urandom);  m0_rw_   = 1'($urandom);
            m1_cs_   = 1'($urandom);  m1_rw_   = 1'($urandom);
            if (!m0_req_) begin
                if (!g0_b) begin
                    if (hold0 == 0) begin
                        m0_req_ = 1'b1;
                        gap0 = $urandom_range(2, 6);
                    end else hold0--;
                end
            end else if (gap0 > 0) gap0--;
            else if ($urandom_range(0, 1) == 1) begin
                m0_req_ = 1'b0;
                hold0 = $urandom_range(1, 30);
            end
            if (!m1_req_) begin
                if (!g1_b) begin
                    if (hold1 == 0) begin
                        m1_req_ = 1'b1;
                        gap1 = $urandom_range(2, 6);
                    end else hold1--;
                end
            end else if (gap1 > 0) gap1--;
            else if ($urandom_range(0, 1) == 1) begin
                m1_req_ = 1'b0;
                hold1 = $urandom_range(1, 30);
            end
        end
        rnd_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
